// File: rtl/game_referee.sv
`default_nettype none
// ============================================================================
// Module   : game_referee
// Purpose  : Round/match referee for a two-player fighting game. It sequences
//            rounds, detects KO/timeout, and tracks best-of-N wins.
// Revision : 1.0  initial release
// ============================================================================
module game_referee #(
    parameter int ROUND_CYCLES  = 30,
    parameter int KO_LIMIT      = 5,
    parameter int WINS_TO_MATCH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [2:0] left_health,
    input  logic [2:0] right_health,
    input  logic [2:0] left_location,
    input  logic [2:0] right_location,
    output logic       players_rst_n,
    output logic       action_enable,
    output logic [4:0] round_timer,
    output logic [1:0] round_result,
    output logic [1:0] left_wins,
    output logic [1:0] right_wins,
    output logic       match_over,
    output logic       in_contact
);

    localparam logic [4:0] c_ROUND_LOAD  = 5'(ROUND_CYCLES);
    localparam logic [2:0] c_KO_LIMIT    = 3'(KO_LIMIT);
    localparam logic [1:0] c_WINS_NEEDED = 2'(WINS_TO_MATCH);

    localparam logic [1:0] c_RES_NONE  = 2'b00;
    localparam logic [1:0] c_RES_LEFT  = 2'b01;
    localparam logic [1:0] c_RES_RIGHT = 2'b10;
    localparam logic [1:0] c_RES_DRAW  = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PREP   = 2'd1,
        FIGHT  = 2'd2,
        RESULT = 2'd3
    } state_t;

    state_t     r_state;

    logic       w_left_ko;
    logic       w_right_ko;
    logic [1:0] w_verdict;
    logic [1:0] w_left_wins_next;
    logic [1:0] w_right_wins_next;
    logic       w_match_next;
    logic [3:0] w_distance;

    assign w_distance = {1'b0, left_location} + {1'b0, right_location};
    assign in_contact = (w_distance <= 4'd1);

    // Health above the legal maximum is a wrapped (underflowed) counter.
    assign w_left_ko  = (left_health  == 3'd0) || (left_health  > c_KO_LIMIT);
    assign w_right_ko = (right_health == 3'd0) || (right_health > c_KO_LIMIT);

    always_comb begin
        w_verdict = c_RES_NONE;
        if (w_left_ko && w_right_ko) begin
            w_verdict = c_RES_DRAW;
        end else if (w_left_ko) begin
            w_verdict = c_RES_RIGHT;
        end else if (w_right_ko) begin
            w_verdict = c_RES_LEFT;
        end else if (round_timer == 5'd1) begin
            if (left_health > right_health) begin
                w_verdict = c_RES_LEFT;
            end else if (right_health > left_health) begin
                w_verdict = c_RES_RIGHT;
            end else begin
                w_verdict = c_RES_DRAW;
            end
        end
    end

    // Saturating counters: a third win is held rather than wrapping to zero.
    always_comb begin
        w_left_wins_next  = left_wins;
        w_right_wins_next = right_wins;
        if (w_verdict == c_RES_LEFT && left_wins != 2'd3) begin
            w_left_wins_next = left_wins + 2'd1;
        end
        if (w_verdict == c_RES_RIGHT && right_wins != 2'd3) begin
            w_right_wins_next = right_wins + 2'd1;
        end
        w_match_next = (w_left_wins_next >= c_WINS_NEEDED) ||
                       (w_right_wins_next >= c_WINS_NEEDED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            players_rst_n <= 1'b0;
            action_enable <= 1'b0;
            round_timer   <= c_ROUND_LOAD;
            round_result  <= c_RES_NONE;
            left_wins     <= 2'd0;
            right_wins    <= 2'd0;
            match_over    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    players_rst_n <= 1'b1;
                    if (start) begin
                        r_state       <= PREP;
                        players_rst_n <= 1'b0;
                        round_timer   <= c_ROUND_LOAD;
                        round_result  <= c_RES_NONE;
                        if (match_over) begin
                            left_wins  <= 2'd0;
                            right_wins <= 2'd0;
                            match_over <= 1'b0;
                        end
                    end
                end
                PREP: begin
                    // Players' health registers settle during this cycle.
                    players_rst_n <= 1'b1;
                    round_timer   <= c_ROUND_LOAD;
                    action_enable <= 1'b1;
                    r_state       <= FIGHT;
                end
                FIGHT: begin
                    round_timer <= round_timer - 5'd1;
                    if (w_verdict != c_RES_NONE) begin
                        action_enable <= 1'b0;
                        round_result  <= w_verdict;
                        left_wins     <= w_left_wins_next;
                        right_wins    <= w_right_wins_next;
                        match_over    <= w_match_next;
                        r_state       <= RESULT;
                    end
                end
                RESULT: begin
                    if (start) begin
                        r_state       <= PREP;
                        players_rst_n <= 1'b0;
                        round_result  <= c_RES_NONE;
                        if (match_over) begin
                            left_wins  <= 2'd0;
                            right_wins <= 2'd0;
                            match_over <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_game_referee.sv
`default_nettype none
// ============================================================================
// Module   : tb_game_referee
// Purpose  : Directed self-checking bench for game_referee.
// Revision : 1.0  initial release
// ============================================================================
module tb_game_referee;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] left_health;
    logic [2:0] right_health;
    logic [2:0] left_location;
    logic [2:0] right_location;
    logic       players_rst_n;
    logic       action_enable;
    logic [4:0] round_timer;
    logic [1:0] round_result;
    logic [1:0] left_wins;
    logic [1:0] right_wins;
    logic       match_over;
    logic       in_contact;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    game_referee #(
        .ROUND_CYCLES  (30),
        .KO_LIMIT      (5),
        .WINS_TO_MATCH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .left_health    (left_health),
        .right_health   (right_health),
        .left_location  (left_location),
        .right_location (right_location),
        .players_rst_n  (players_rst_n),
        .action_enable  (action_enable),
        .round_timer    (round_timer),
        .round_result   (round_result),
        .left_wins      (left_wins),
        .right_wins     (right_wins),
        .match_over     (match_over),
        .in_contact     (in_contact)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input int observed, input int expected);
        total++;
        assert (observed === expected) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    endtask

    // Pulse start from IDLE/RESULT, then step through PREP into FIGHT.
    task automatic begin_round(input logic [2:0] lh, input logic [2:0] rh);
        start = 1'b1;
        tick();
        start = 1'b0;
        left_health  = lh;
        right_health = rh;
        tick();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0;
        left_health = 3'd3; right_health = 3'd3;
        left_location = 3'd2; right_location = 3'd2;
        tick();
        check("rst_players_rst_n", int'(players_rst_n), 0);
        check("rst_action_enable", int'(action_enable), 0);
        check("rst_round_timer",   int'(round_timer), 30);
        check("rst_round_result",  int'(round_result), 0);
        check("rst_left_wins",     int'(left_wins), 0);
        check("rst_right_wins",    int'(right_wins), 0);
        check("rst_match_over",    int'(match_over), 0);

        rst = 1'b0;
        tick();
        check("idle_players_rst_n", int'(players_rst_n), 1);
        check("contact_far", int'(in_contact), 0);
        left_location = 3'd0; right_location = 3'd1;
        #1;
        check("contact_near", int'(in_contact), 1);
        left_location = 3'd1; right_location = 3'd1;
        #1;
        check("contact_two", int'(in_contact), 0);

        // Round 1: start handshake, then right underflows 3->1->7.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("prep_players_rst_n", int'(players_rst_n), 0);
        check("prep_action_enable", int'(action_enable), 0);
        tick();
        check("fight_players_rst_n", int'(players_rst_n), 1);
        check("fight_action_enable", int'(action_enable), 1);
        check("fight_round_timer",   int'(round_timer), 30);
        right_health = 3'd1;
        tick();
        check("r1_timer_dec", int'(round_timer), 29);
        check("r1_still_fighting", int'(round_result), 0);
        right_health = 3'd7;
        tick();
        check("r1_result", int'(round_result), 1);
        check("r1_left_wins", int'(left_wins), 1);
        check("r1_action_enable", int'(action_enable), 0);
        check("r1_match_over", int'(match_over), 0);

        // Round 2: double KO is a draw and awards nothing.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("r2_prep_result_clear", int'(round_result), 0);
        left_health = 3'd3; right_health = 3'd3;
        tick();
        left_health = 3'd0; right_health = 3'd0;
        tick();
        check("r2_result", int'(round_result), 3);
        check("r2_left_wins", int'(left_wins), 1);
        check("r2_right_wins", int'(right_wins), 0);

        // Round 3: timeout with 4 vs 3 gives left its second win.
        begin_round(3'd4, 3'd3);
        ticks(29);
        check("r3_last_cycle_timer", int'(round_timer), 1);
        check("r3_last_cycle_enable", int'(action_enable), 1);
        check("r3_last_cycle_result", int'(round_result), 0);
        tick();
        check("r3_result", int'(round_result), 1);
        check("r3_left_wins", int'(left_wins), 2);
        check("r3_match_over", int'(match_over), 1);

        // New match: counters clear on the start edge.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("nm_left_wins", int'(left_wins), 0);
        check("nm_right_wins", int'(right_wins), 0);
        check("nm_match_over", int'(match_over), 0);
        check("nm_prep_pulse", int'(players_rst_n), 0);
        left_health = 3'd3; right_health = 3'd3;
        tick();

        // Equal-health timeout draws.
        ticks(29);
        tick();
        check("r4_result", int'(round_result), 3);
        check("r4_left_wins", int'(left_wins), 0);
        check("r4_right_wins", int'(right_wins), 0);

        // KO on the timeout cycle overrides the health comparison.
        begin_round(3'd5, 3'd3);
        ticks(29);
        left_health = 3'd0;
        tick();
        check("r5_result", int'(round_result), 2);
        check("r5_right_wins", int'(right_wins), 1);

        // Start is ignored mid-fight; then rst abandons the round.
        begin_round(3'd3, 3'd3);
        ticks(10);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("r6_start_ignored_rst_n", int'(players_rst_n), 1);
        check("r6_start_ignored_timer", int'(round_timer), 19);
        ticks(7);
        check("r6_timer_12", int'(round_timer), 12);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_action_enable", int'(action_enable), 0);
        check("mid_rst_round_timer", int'(round_timer), 30);
        check("mid_rst_right_wins", int'(right_wins), 0);
        check("mid_rst_result", int'(round_result), 0);
        tick();
        check("mid_rst_idle", int'(players_rst_n), 1);
        check("mid_rst_idle_enable", int'(action_enable), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/game_referee.md
Name: game_referee

Overview:
- Sits directly downstream of both player blocks.
- Consumes each player's registered health and location, and runs the round: start, round timer, KO/timeout detection, winner decision.
- Issues a one-cycle active-low reset pulse to both players at each round start.
- Gates player actions through action_enable and keeps per-player round-win counters for a best-of-N match.

Parameters:
- ROUND_CYCLES, 30, clock cycles per round before timeout (≥2).
- KO_LIMIT, 5, maximum legal health. Any value above it is an underflowed (wrapped) 3-bit health and counts as KO.
- WINS_TO_MATCH, 2, round wins needed to win the match.

Ports:
- clk  in  1  clock. Single clock domain.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle request to begin next round/match.
- left_health  in  3  left player registered health.
- right_health  in  3  right player registered health.
- left_location  in  3  left player distance from centre (0..2).
- right_location  in  3  right player distance from centre (0..2).
- players_rst_n  out  1  active-low reset pulse to both players.
- action_enable  out  1  1 only while FIGHT; upstream forces WAIT-free idle (6'b000000) when 0.
- round_timer  out  5  cycles remaining in round.
- round_result  out  2  00 none, 01 left, 10 right, 11 draw.
- left_wins  out  2  rounds won by left in current match.
- right_wins  out  2  rounds won by right in current match.
- match_over  out  1  high when either wins counter reaches WINS_TO_MATCH.
- in_contact  out  1  combinational: left_location+right_location ≤ 1.

Behaviour:
- Reset (rst=1 at clk edge): state IDLE; players_rst_n=0; action_enable=0; round_timer=ROUND_CYCLES; round_result=00; left_wins=right_wins=0; match_over=0. rst mid-round abandons the round, no result recorded.
- States: IDLE, PREP, FIGHT, RESULT.
- IDLE:
  - players_rst_n=1.
  - start=1 → PREP, players_rst_n=0 for exactly that next cycle.
  - If match_over was set, the win counters and match_over clear on the same edge.
- PREP:
  - One cycle long; lets player health outputs settle to 3 (their output registers lag one cycle).
  - → FIGHT with round_timer=ROUND_CYCLES and action_enable=1.
- FIGHT:
  - round_timer decrements by 1 per cycle.
  - KO per player: health==0 or health>KO_LIMIT.
  - Checks are evaluated every cycle in priority order:
    - 1. Both KO → draw (11).
    - 2. Left KO → right wins (10).
    - 3. Right KO → left wins (01).
    - 4. round_timer==1 (last cycle) → higher health wins; equal health → draw.
  - On any decision: action_enable=0, round_result set, winner's counter +1 (saturates at 3, never wraps), → RESULT.
  - KO and timeout on the same cycle: KO rule wins.
- RESULT:
  - Holds round_result and counters.
  - match_over=1 if left_wins or right_wins ≥ WINS_TO_MATCH.
  - start=1 → PREP (new round), round_result cleared to 00.
  - If match_over, counters also clear and a new match begins.
- start is ignored in PREP and FIGHT.
- round_timer holds its value in RESULT and reloads in PREP.
- All outputs are registered except in_contact.
- Draws increment neither counter.

Test Plan:
- Reset then start → players_rst_n low exactly one cycle, action_enable rises 2 cycles after start, round_timer=30.
- FIGHT, right_health 3→1→7 (underflow) → next cycle round_result=01, left_wins=1, action_enable=0.
- Both healths 0 on the same cycle → round_result=11, counters unchanged.
- No hits for 30 cycles, left_health=4, right_health=3 → at timeout round_result=01. Repeat with equal health 3/3 → 11.
- Left wins two rounds → match_over=1. Next start → left_wins=right_wins=0, match_over=0, PREP entered.
- rst asserted mid-FIGHT with timer=12 → next cycle IDLE, counters 0, round_timer=30, action_enable=0.
